// File: rtl/heart_pkg.sv
// Shared types and default geometry for the heart sprite controller.
// The centre() helper computes the reset position inside the battle box.
package heart_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        INVULN = 1'b1
    } inv_state_t;

    localparam int         SPR_W_DEF      = 15;
    localparam int         SPR_H_DEF      = 15;
    localparam logic [7:0] TRANSP_DEF     = 8'h00;

    localparam int         BOX_X0_DEF     = 220;
    localparam int         BOX_X1_DEF     = 420;
    localparam int         BOX_Y0_DEF     = 250;
    localparam int         BOX_Y1_DEF     = 400;

    localparam int         STEP_DEF       = 2;
    localparam int         INV_FRAMES_DEF = 60;

    function automatic logic [9:0] centre(input int lo, input int hi, input int sz);
        return 10'((lo + hi - sz) / 2);
    endfunction

endpackage

// File: rtl/heart_move.sv
// One axis of heart movement: steps once per frame tick and clamps to [LO, HI].
module heart_move
    import heart_pkg::*;
#(
    parameter int         LO      = BOX_X0_DEF,
    parameter int         HI      = BOX_X1_DEF - SPR_W_DEF,
    parameter int         STEP    = STEP_DEF,
    parameter logic [9:0] RST_POS = 10'd0
) (
    input  logic       i_clk2,
    input  logic       i_rst,
    input  logic       tick,
    input  logic       inc,
    input  logic       dec,
    output logic [9:0] pos
);

    localparam logic signed [10:0] LO_S   = 11'(LO);
    localparam logic signed [10:0] HI_S   = 11'(HI);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    logic signed [10:0] cur;
    logic signed [10:0] moved;
    logic signed [10:0] nxt;

    // Signed 11-bit arithmetic lets a step below zero clamp instead of wrapping.
    always_comb begin
        cur   = signed'({1'b0, pos});
        moved = cur;
        if (inc && !dec) begin
            moved = cur + STEP_S;
        end else if (dec && !inc) begin
            moved = cur - STEP_S;
        end
        nxt = moved;
        if (moved < LO_S) begin
            nxt = LO_S;
        end else if (moved > HI_S) begin
            nxt = HI_S;
        end
    end

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            pos <= RST_POS;
        end else if (tick) begin
            pos <= 10'(nxt);
        end
    end

endmodule

// File: rtl/heart_sprite_ctrl.sv
// Heart sprite controller: position, ROM addressing, pixel pipeline and blink.
// Define HEART_BLINK_EN to build the post-hit invulnerability FSM and blink.
module heart_sprite_ctrl
    import heart_pkg::*;
#(
    parameter int         SPR_W      = SPR_W_DEF,
    parameter int         SPR_H      = SPR_H_DEF,
    parameter int         BOX_X0     = BOX_X0_DEF,
    parameter int         BOX_X1     = BOX_X1_DEF,
    parameter int         BOX_Y0     = BOX_Y0_DEF,
    parameter int         BOX_Y1     = BOX_Y1_DEF,
    parameter int         STEP       = STEP_DEF,
    parameter int         INV_FRAMES = INV_FRAMES_DEF,
    parameter logic [7:0] TRANSP     = TRANSP_DEF
) (
    input  logic       i_clk2,
    input  logic       i_rst,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_frame_tick,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_hit,
    output logic [9:0] o_rom_addr,
    input  logic [7:0] i_rom_data,
    output logic [7:0] o_pixel,
    output logic       o_pixel_valid,
    output logic [9:0] o_heart_x,
    output logic [9:0] o_heart_y,
    output logic       o_invuln
);

    localparam logic [9:0] X_RST = centre(BOX_X0, BOX_X1, SPR_W);
    localparam logic [9:0] Y_RST = centre(BOX_Y0, BOX_Y1, SPR_H);

    heart_move #(
        .LO     (BOX_X0),
        .HI     (BOX_X1 - SPR_W),
        .STEP   (STEP),
        .RST_POS(X_RST)
    ) u_move_x (
        .i_clk2(i_clk2),
        .i_rst (i_rst),
        .tick  (i_frame_tick),
        .inc   (i_right),
        .dec   (i_left),
        .pos   (o_heart_x)
    );

    heart_move #(
        .LO     (BOX_Y0),
        .HI     (BOX_Y1 - SPR_H),
        .STEP   (STEP),
        .RST_POS(Y_RST)
    ) u_move_y (
        .i_clk2(i_clk2),
        .i_rst (i_rst),
        .tick  (i_frame_tick),
        .inc   (i_down),
        .dec   (i_up),
        .pos   (o_heart_y)
    );

    logic visible;

`ifdef HEART_BLINK_EN
    localparam int CW = $clog2(INV_FRAMES + 1);

    inv_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            state <= NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A hit during invulnerability is ignored; the tick that empties the counter ends it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            NORMAL: begin
                if (i_hit) begin
                    cnt_nx   = CW'(INV_FRAMES);
                    state_nx = INVULN;
                end
            end
            INVULN: begin
                if (i_frame_tick) begin
                    cnt_nx = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_nx = NORMAL;
                    end
                end
            end
        endcase
    end

    assign o_invuln = (state == INVULN);
    assign visible  = (state == NORMAL) || !cnt[2];
`else
    localparam int unused_inv_frames = INV_FRAMES;
    logic unused_hit;

    assign unused_hit = i_hit;
    assign o_invuln   = 1'b0;
    assign visible    = 1'b1;
`endif

    logic [9:0] dx, dy, addr_c;
    logic       in_spr;

    // Unsigned wrap-around makes scan positions left of / above the heart look huge.
    always_comb begin
        dx     = i_x - o_heart_x;
        dy     = i_y - o_heart_y;
        in_spr = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
        addr_c = '0;
        if (in_spr) begin
            addr_c = dy * 10'(SPR_W) + dx;
        end
    end

    logic in_spr_d1, vis_d1, in_spr_d2, vis_d2, pix_ok;

    assign pix_ok = in_spr_d2 && vis_d2 && (i_rom_data != TRANSP);

    // Flags ride two stages to line up with the ROM's registered read data.
    always_ff @(posedge i_clk2) begin
        if (i_rst) begin
            o_rom_addr    <= '0;
            in_spr_d1     <= 1'b0;
            vis_d1        <= 1'b0;
            in_spr_d2     <= 1'b0;
            vis_d2        <= 1'b0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
        end else begin
            o_rom_addr    <= addr_c;
            in_spr_d1     <= in_spr;
            vis_d1        <= visible;
            in_spr_d2     <= in_spr_d1;
            vis_d2        <= vis_d1;
            o_pixel       <= pix_ok ? i_rom_data : 8'h00;
            o_pixel_valid <= pix_ok;
        end
    end

endmodule

// File: tb/tb_heart_sprite_ctrl.sv
// Self-checking bench for heart_sprite_ctrl; covers both HEART_BLINK_EN builds.
module tb_heart_sprite_ctrl;

    logic       i_clk2       = 1'b0;
    logic       i_rst        = 1'b1;
    logic [9:0] i_x          = '0;
    logic [9:0] i_y          = '0;
    logic       i_frame_tick = 1'b0;
    logic       i_up         = 1'b0;
    logic       i_down       = 1'b0;
    logic       i_left       = 1'b0;
    logic       i_right      = 1'b0;
    logic       i_hit        = 1'b0;
    logic [7:0] i_rom_data   = '0;
    logic [9:0] o_rom_addr;
    logic [7:0] o_pixel;
    logic       o_pixel_valid;
    logic [9:0] o_heart_x;
    logic [9:0] o_heart_y;
    logic       o_invuln;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    heart_sprite_ctrl dut (
        .i_clk2       (i_clk2),
        .i_rst        (i_rst),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_frame_tick (i_frame_tick),
        .i_up         (i_up),
        .i_down       (i_down),
        .i_left       (i_left),
        .i_right      (i_right),
        .i_hit        (i_hit),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_pixel      (o_pixel),
        .o_pixel_valid(o_pixel_valid),
        .o_heart_x    (o_heart_x),
        .o_heart_y    (o_heart_y),
        .o_invuln     (o_invuln)
    );

    always #5 i_clk2 = ~i_clk2;

    always @(posedge i_clk2) cyc <= cyc + 1;

    // Sprite ROM model: one-cycle registered read.
    logic [7:0] rom_mem [0:1023];
    always @(posedge i_clk2) i_rom_data <= rom_mem[o_rom_addr];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] addr;
        logic       valid;
        logic [7:0] pix;
    } vec_t;

    typedef struct {
        int         due;
        logic [9:0] addr;
    } aexp_t;

    typedef struct {
        int         due;
        logic       valid;
        logic [7:0] pix;
    } pexp_t;

    aexp_t aq[$];
    pexp_t pq[$];
    vec_t  vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge i_clk2);
        #1;
    endtask

    // Drives one scan position for one cycle and queues its expected results.
    task automatic applyStimulus(input vec_t v);
        aexp_t a;
        pexp_t p;
        i_x     = v.x;
        i_y     = v.y;
        a.due   = cyc + 1;
        a.addr  = v.addr;
        p.due   = cyc + 3;
        p.valid = v.valid;
        p.pix   = v.pix;
        aq.push_back(a);
        pq.push_back(p);
        runCycles(1);
    endtask

    task automatic frameTick(input logic up, input logic down, input logic left, input logic right);
        i_up         = up;
        i_down       = down;
        i_left       = left;
        i_right      = right;
        i_frame_tick = 1'b1;
        runCycles(1);
        i_frame_tick = 1'b0;
        i_up         = 1'b0;
        i_down       = 1'b0;
        i_left       = 1'b0;
        i_right      = 1'b0;
    endtask

    // Scoreboard: address checked one cycle after drive, pixel three cycles after.
    always @(negedge i_clk2) begin
        if (aq.size() > 0 && aq[0].due <= cyc) begin
            aexp_t a;
            a = aq.pop_front();
            checkOutput("rom_addr", 32'(o_rom_addr), 32'(a.addr));
        end
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            pexp_t p;
            p = pq.pop_front();
            checkOutput("pixel_valid", 32'(o_pixel_valid), 32'(p.valid));
            checkOutput("pixel", 32'(o_pixel), 32'(p.pix));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int a = 0; a < 1024; a++) rom_mem[a] = 8'(a + 16);
        rom_mem[16]  = 8'h00;
        rom_mem[224] = 8'hE0;

        // Heart sits at (312,317) after reset.
        vecs[0] = '{x: 10'd312, y: 10'd317, addr: 10'd0,   valid: 1'b1, pix: 8'h10};
        vecs[1] = '{x: 10'd326, y: 10'd331, addr: 10'd224, valid: 1'b1, pix: 8'hE0};
        vecs[2] = '{x: 10'd311, y: 10'd317, addr: 10'd0,   valid: 1'b0, pix: 8'h00};
        vecs[3] = '{x: 10'd313, y: 10'd318, addr: 10'd16,  valid: 1'b0, pix: 8'h00};
        vecs[4] = '{x: 10'd327, y: 10'd317, addr: 10'd0,   valid: 1'b0, pix: 8'h00};
        vecs[5] = '{x: 10'd312, y: 10'd332, addr: 10'd0,   valid: 1'b0, pix: 8'h00};
        vecs[6] = '{x: 10'd320, y: 10'd320, addr: 10'd53,  valid: 1'b1, pix: 8'h45};
        vecs[7] = '{x: 10'd0,   y: 10'd0,   addr: 10'd0,   valid: 1'b0, pix: 8'h00};
        vecs[8] = '{x: 10'd326, y: 10'd317, addr: 10'd14,  valid: 1'b1, pix: 8'h1E};
        vecs[9] = '{x: 10'd312, y: 10'd331, addr: 10'd210, valid: 1'b1, pix: 8'hE2};

        runCycles(3);
        i_rst = 1'b0;
        checkOutput("reset_heart_x", 32'(o_heart_x), 32'd312);
        checkOutput("reset_heart_y", 32'(o_heart_y), 32'd317);
        checkOutput("reset_rom_addr", 32'(o_rom_addr), 32'd0);
        checkOutput("reset_pixel", 32'(o_pixel), 32'd0);
        checkOutput("reset_pixel_valid", 32'(o_pixel_valid), 32'd0);
        checkOutput("reset_invuln", 32'(o_invuln), 32'd0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
        i_x = '0;
        i_y = '0;
        runCycles(5);
        checkOutput("sb_addr_drained", 32'(aq.size()), 32'd0);
        checkOutput("sb_pix_drained", 32'(pq.size()), 32'd0);

        // Movement only happens on frame ticks.
        frameTick(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_tick_x", 32'(o_heart_x), 32'd312);
        i_right = 1'b1;
        runCycles(3);
        i_right = 1'b0;
        checkOutput("no_tick_x", 32'(o_heart_x), 32'd312);

        for (int i = 0; i < 60; i++) begin
            frameTick(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 0) checkOutput("right_first_x", 32'(o_heart_x), 32'd314);
        end
        checkOutput("right_clamp_x", 32'(o_heart_x), 32'd405);
        checkOutput("right_y_unchanged", 32'(o_heart_y), 32'd317);
        frameTick(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("left_right_both_x", 32'(o_heart_x), 32'd405);

        for (int i = 0; i < 92; i++) frameTick(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("left_to_221_x", 32'(o_heart_x), 32'd221);
        frameTick(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("left_clamp_220_x", 32'(o_heart_x), 32'd220);
        frameTick(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("left_hold_220_x", 32'(o_heart_x), 32'd220);

        for (int i = 0; i < 40; i++) frameTick(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("down_clamp_y", 32'(o_heart_y), 32'd385);
        frameTick(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("up_one_y", 32'(o_heart_y), 32'd383);
        for (int i = 0; i < 70; i++) frameTick(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("up_clamp_y", 32'(o_heart_y), 32'd250);

        // Reset mid-frame with a live pixel in the pipeline.
        for (int i = 0; i < 5; i++) frameTick(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("move_230_x", 32'(o_heart_x), 32'd230);
        i_x = 10'd232;
        i_y = 10'd250;
        runCycles(4);
        checkOutput("live_pixel_valid", 32'(o_pixel_valid), 32'd1);
        checkOutput("live_pixel", 32'(o_pixel), 32'h12);
        i_rst = 1'b1;
        runCycles(1);
        checkOutput("midrst_pixel_valid", 32'(o_pixel_valid), 32'd0);
        checkOutput("midrst_rom_addr", 32'(o_rom_addr), 32'd0);
        checkOutput("midrst_heart_x", 32'(o_heart_x), 32'd312);
        checkOutput("midrst_heart_y", 32'(o_heart_y), 32'd317);
        i_rst = 1'b0;
        i_x   = 10'd312;
        i_y   = 10'd317;
        runCycles(4);
        checkOutput("post_rst_pixel_valid", 32'(o_pixel_valid), 32'd1);

`ifdef HEART_BLINK_EN
        begin
            int exp_cnt;
            i_hit = 1'b1;
            runCycles(1);
            i_hit = 1'b0;
            checkOutput("hit_invuln", 32'(o_invuln), 32'd1);
            exp_cnt = 60;
            while (exp_cnt > 0) begin
                if (exp_cnt == 30) begin
                    i_hit = 1'b1;
                    runCycles(1);
                    i_hit = 1'b0;
                    checkOutput("rehit_invuln", 32'(o_invuln), 32'd1);
                end
                runCycles(4);
                checkOutput("blink_visible", 32'(o_pixel_valid), 32'((exp_cnt & 4) == 0));
                frameTick(1'b0, 1'b0, 1'b0, 1'b0);
                exp_cnt--;
                checkOutput("blink_invuln", 32'(o_invuln), 32'(exp_cnt != 0));
            end
            runCycles(4);
            checkOutput("after_invuln_visible", 32'(o_pixel_valid), 32'd1);

            // Hit and tick in the same cycle: full load, no decrement.
            i_hit        = 1'b1;
            i_frame_tick = 1'b1;
            runCycles(1);
            i_hit        = 1'b0;
            i_frame_tick = 1'b0;
            checkOutput("coinc_invuln", 32'(o_invuln), 32'd1);
            for (int i = 0; i < 59; i++) frameTick(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("coinc_59_invuln", 32'(o_invuln), 32'd1);
            frameTick(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("coinc_60_invuln", 32'(o_invuln), 32'd0);

            i_hit = 1'b1;
            runCycles(1);
            i_hit = 1'b0;
            for (int i = 0; i < 40; i++) frameTick(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("cnt20_invuln", 32'(o_invuln), 32'd1);
            checkOutput("cnt20_heart_x", 32'(o_heart_x), 32'd392);
            i_rst = 1'b1;
            runCycles(1);
            checkOutput("rst20_invuln", 32'(o_invuln), 32'd0);
            checkOutput("rst20_heart_x", 32'(o_heart_x), 32'd312);
            checkOutput("rst20_heart_y", 32'(o_heart_y), 32'd317);
            checkOutput("rst20_pixel_valid", 32'(o_pixel_valid), 32'd0);
            i_rst = 1'b0;
            runCycles(4);
            checkOutput("rst20_visible", 32'(o_pixel_valid), 32'd1);
        end
`else
        for (int i = 0; i < 6; i++) begin
            i_hit = 1'b1;
            runCycles(1);
            i_hit = 1'b0;
            checkOutput("nohit_invuln", 32'(o_invuln), 32'd0);
            frameTick(1'b0, 1'b0, 1'b0, 1'b0);
            runCycles(3);
            checkOutput("nohit_visible", 32'(o_pixel_valid), 32'd1);
            checkOutput("nohit_pixel", 32'(o_pixel), 32'h10);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
